// File: rtl/voting_machine_param.sv
// Parametrised ballot-armed voting machine: per-button sync/debounce/long-press
// qualification, saturating tallies, and a registered winner/tie tracker.
module voting_machine_param #(
  parameter int NUM_CAND          = 4,
  parameter int COUNT_W           = 8,
  parameter int DEBOUNCE_CYCLES   = 500,
  parameter int LONG_PRESS_CYCLES = 11,
  parameter int BLINK_CYCLES      = 16,
  parameter int ID_W              = $clog2(NUM_CAND + 1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        mode,
  input  logic                        ballot_arm,
  input  logic [NUM_CAND-1:0]         button_raw,
  output logic [COUNT_W-1:0]          led,
  output logic                        armed,
  output logic                        vote_ok,
  output logic                        vote_reject,
  output logic [NUM_CAND*COUNT_W-1:0] cand_count,
  output logic [ID_W-1:0]             winner_id,
  output logic [COUNT_W-1:0]          winner_votes,
  output logic                        tie,
  output logic                        saturated
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LP_W  = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int BLK_W = $clog2(BLINK_CYCLES + 1);

  localparam logic [DEB_W-1:0]   DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LP_W-1:0]    LP_MAX   = LP_W'(LONG_PRESS_CYCLES);
  localparam logic [LP_W-1:0]    LP_PRE   = LP_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [BLK_W-1:0]   BLK_LAST = BLK_W'(BLINK_CYCLES - 1);
  localparam logic [COUNT_W-1:0] ALL_ONES = '1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ARMED    = 2'd1;
  localparam logic [1:0] S_BLINK    = 2'd2;
  localparam logic [1:0] S_WAIT_REL = 2'd3;

  logic [NUM_CAND-1:0] sync1_q, sync2_q;
  logic [NUM_CAND-1:0] deb_q, deb_d;
  logic [NUM_CAND-1:0] qual_q, qual_d;
  logic [DEB_W-1:0]    deb_cnt_q [NUM_CAND];
  logic [DEB_W-1:0]    deb_cnt_d [NUM_CAND];
  logic [LP_W-1:0]     lp_cnt_q  [NUM_CAND];
  logic [LP_W-1:0]     lp_cnt_d  [NUM_CAND];

  logic [1:0]          state_q, state_d;
  logic                held_q, held_d;
  logic [BLK_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic                vote_ok_q, vote_ok_d;
  logic                vote_reject_q, vote_reject_d;

  logic [COUNT_W-1:0]  tally_q [NUM_CAND];
  logic [COUNT_W-1:0]  tally_d [NUM_CAND];
  logic                saturated_q, saturated_d;

  logic [COUNT_W-1:0]  max_v;
  logic [ID_W-1:0]     max_idx;
  int                  n_max;
  logic [ID_W-1:0]     winner_id_q, winner_id_d;
  logic [COUNT_W-1:0]  winner_votes_q, winner_votes_d;
  logic                tie_q, tie_d;
  logic [COUNT_W-1:0]  led_q, led_d;

  logic any_held, any_qual, one_qual, other_held;

  // Debounce and long-press qualification, one independent channel per button.
  always_comb begin
    for (int i = 0; i < NUM_CAND; i++) begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      deb_d[i]     = deb_q[i];
      deb_cnt_d[i] = '0;
      lp_cnt_d[i]  = '0;
      qual_d[i]    = 1'b0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
        else                          deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
      end
      if (deb_q[i]) begin
        lp_cnt_d[i] = (lp_cnt_q[i] == LP_MAX) ? lp_cnt_q[i] : lp_cnt_q[i] + LP_W'(1);
        qual_d[i]   = (lp_cnt_q[i] == LP_PRE);
      end
    end
  end

  assign any_held   = |deb_q;
  assign any_qual   = |qual_q;
  assign one_qual   = ($countones(qual_q) == 1);
  assign other_held = |(deb_q & ~qual_q);

  always_comb begin
    state_d       = state_q;
    held_d        = held_q;
    blink_cnt_d   = blink_cnt_q;
    vote_ok_d     = 1'b0;
    vote_reject_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ballot_arm && !mode) begin
          state_d = S_ARMED;
          held_d  = 1'b1;
        end
      end
      S_ARMED: begin
        if (mode) begin
          state_d = S_IDLE;
          held_d  = 1'b0;
        end else if (any_qual) begin
          if (one_qual && !other_held) begin
            vote_ok_d   = 1'b1;
            held_d      = 1'b0;
            blink_cnt_d = '0;
            state_d     = S_BLINK;
          end else begin
            vote_reject_d = 1'b1;
            state_d       = S_WAIT_REL;
          end
        end
      end
      S_BLINK: begin
        if (blink_cnt_q == BLK_LAST) state_d = S_WAIT_REL;
        else                         blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
      default: begin
        // A mode switch while waiting for release also withdraws the held ballot.
        if (mode) held_d = 1'b0;
        if (!any_held) state_d = (held_q && !mode) ? S_ARMED : S_IDLE;
      end
    endcase
  end

  always_comb begin
    saturated_d = saturated_q;
    for (int i = 0; i < NUM_CAND; i++) begin
      tally_d[i] = tally_q[i];
      if (vote_ok_d && qual_q[i] && tally_q[i] != ALL_ONES) tally_d[i] = tally_q[i] + COUNT_W'(1);
      if (tally_d[i] == ALL_ONES) saturated_d = 1'b1;
    end
  end

  // Leader search works on registered tallies, so results trail a vote by one cycle.
  always_comb begin
    max_v   = '0;
    max_idx = '0;
    n_max   = 0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (tally_q[i] > max_v) begin
        max_v   = tally_q[i];
        max_idx = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_CAND; i++) begin
      if (tally_q[i] == max_v) n_max = n_max + 1;
    end
    winner_id_d    = (max_v == '0) ? '0 : max_idx + ID_W'(1);
    winner_votes_d = max_v;
    tie_d          = (max_v != '0) && (n_max >= 2);
  end

  always_comb begin
    led_d = '0;
    if (!mode) begin
      if (state_d == S_BLINK) led_d = ALL_ONES;
    end else begin
      led_d = winner_votes_q;
      for (int i = NUM_CAND - 1; i >= 0; i--) begin
        if (deb_q[i]) led_d = tally_q[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      deb_q          <= '0;
      qual_q         <= '0;
      state_q        <= S_IDLE;
      held_q         <= 1'b0;
      blink_cnt_q    <= '0;
      vote_ok_q      <= 1'b0;
      vote_reject_q  <= 1'b0;
      saturated_q    <= 1'b0;
      winner_id_q    <= '0;
      winner_votes_q <= '0;
      tie_q          <= 1'b0;
      led_q          <= '0;
      // NOTE: the tally array is a handful of flops, not RAM, so clearing it on reset is cheap and required.
      for (int i = 0; i < NUM_CAND; i++) begin
        deb_cnt_q[i] <= '0;
        lp_cnt_q[i]  <= '0;
        tally_q[i]   <= '0;
      end
    end else begin
      sync1_q        <= button_raw;
      sync2_q        <= sync1_q;
      deb_q          <= deb_d;
      qual_q         <= qual_d;
      state_q        <= state_d;
      held_q         <= held_d;
      blink_cnt_q    <= blink_cnt_d;
      vote_ok_q      <= vote_ok_d;
      vote_reject_q  <= vote_reject_d;
      saturated_q    <= saturated_d;
      winner_id_q    <= winner_id_d;
      winner_votes_q <= winner_votes_d;
      tie_q          <= tie_d;
      led_q          <= led_d;
      for (int i = 0; i < NUM_CAND; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
        lp_cnt_q[i]  <= lp_cnt_d[i];
        tally_q[i]   <= tally_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_pack
    assign cand_count[g*COUNT_W +: COUNT_W] = tally_q[g];
  end

  assign led          = led_q;
  assign armed        = held_q;
  assign vote_ok      = vote_ok_q;
  assign vote_reject  = vote_reject_q;
  assign winner_id    = winner_id_q;
  assign winner_votes = winner_votes_q;
  assign tie          = tie_q;
  assign saturated    = saturated_q;

endmodule

// File: tb/tb_voting_machine_param.sv
// Scoreboarded bench for voting_machine_param with short debounce/long-press/blink
// timings; vote/reject events are matched against a queue of expected tallies.
module tb_voting_machine_param;

  localparam int NC = 4;
  localparam int CW = 4;
  localparam int IW = 3;

  logic             clock;
  logic             reset;
  logic             mode;
  logic             ballot_arm;
  logic [NC-1:0]    button_raw;
  logic [CW-1:0]    led;
  logic             armed;
  logic             vote_ok;
  logic             vote_reject;
  logic [NC*CW-1:0] cand_count;
  logic [IW-1:0]    winner_id;
  logic [CW-1:0]    winner_votes;
  logic             tie;
  logic             saturated;

  voting_machine_param #(
    .NUM_CAND(NC), .COUNT_W(CW), .DEBOUNCE_CYCLES(4),
    .LONG_PRESS_CYCLES(3), .BLINK_CYCLES(4)
  ) dut (
    .clock(clock), .reset(reset), .mode(mode), .ballot_arm(ballot_arm),
    .button_raw(button_raw), .led(led), .armed(armed), .vote_ok(vote_ok),
    .vote_reject(vote_reject), .cand_count(cand_count), .winner_id(winner_id),
    .winner_votes(winner_votes), .tie(tie), .saturated(saturated)
  );

  typedef struct packed {
    logic             is_vote;
    logic [NC*CW-1:0] counts;
  } exp_t;

  exp_t     exp_q[$];
  int       checks = 0;
  int       errors = 0;
  int       n_ok   = 0;
  int       n_rej  = 0;
  int       mc[NC];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NC*CW-1:0] model_counts();
    logic [NC*CW-1:0] v;
    for (int i = 0; i < NC; i++) v[i*CW +: CW] = CW'(mc[i]);
    return v;
  endfunction

  // Scoreboard monitor: every vote/reject pulse consumes one expected event.
  always @(negedge clock) begin
    if (!reset && (vote_ok || vote_reject)) begin
      if (vote_ok) n_ok++;
      if (vote_reject) n_rej++;
      if (exp_q.size() == 0) begin
        check("unexpected_event", {30'd0, vote_ok, vote_reject}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("event_kind", {30'd0, vote_ok, vote_reject}, e.is_vote ? 32'd2 : 32'd1);
        check("event_counts", 32'(cand_count), 32'(e.counts));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic arm();
    ballot_arm = 1'b1;
    cycles(1);
    ballot_arm = 1'b0;
  endtask

  task automatic press(input logic [NC-1:0] mask, input int hold, input int rel);
    button_raw = mask;
    cycles(hold);
    button_raw = '0;
    cycles(rel);
  endtask

  task automatic push_vote(input int idx);
    exp_t e;
    if (mc[idx] < (1 << CW) - 1) mc[idx]++;
    e.is_vote = 1'b1;
    e.counts  = model_counts();
    exp_q.push_back(e);
  endtask

  task automatic vote(input int idx);
    push_vote(idx);
    arm();
    press(NC'(1 << idx), 14, 12);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int nblink;
    int ok0;
    int rej0;
    exp_t e;
    for (int i = 0; i < NC; i++) mc[i] = 0;
    reset = 1'b1; mode = 1'b0; ballot_arm = 1'b0; button_raw = '0;
    cycles(3);
    reset = 1'b0;
    @(negedge clock);
    check("rst_armed", 32'(armed), 0);
    check("rst_led", 32'(led), 0);
    check("rst_counts", 32'(cand_count), 0);
    check("rst_winner", 32'(winner_id), 0);
    check("rst_votes", 32'(winner_votes), 0);
    check("rst_tie_sat", {30'd0, tie, saturated}, 0);
    check("rst_pulses", {30'd0, vote_ok, vote_reject}, 0);
    cycles(1);

    // Single vote for candidate 2 with blink window.
    arm();
    @(negedge clock);
    check("t1_armed", 32'(armed), 1);
    cycles(1);
    push_vote(1);
    button_raw = 4'b0010;
    got = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (vote_ok) begin got = k; break; end
    end
    check("t1_vote_seen", 32'(got >= 0), 1);
    nblink = (led == 4'hF) ? 1 : 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      if (led == 4'hF) nblink++;
    end
    check("t1_blink_len", 32'(nblink), 4);
    check("t1_armed_after", 32'(armed), 0);
    check("t1_count2", 32'(cand_count[1*CW +: CW]), 1);
    check("t1_winner", 32'(winner_id), 2);
    check("t1_votes", 32'(winner_votes), 1);
    check("t1_tie", 32'(tie), 0);
    cycles(1);
    button_raw = '0;
    cycles(12);

    // Presses without a ballot, or in result mode, are ignored.
    ok0 = n_ok;
    press(4'b0001, 14, 12);
    arm();
    mode = 1'b1;
    cycles(2);
    @(negedge clock);
    check("t2_disarm", 32'(armed), 0);
    cycles(1);
    press(4'b0001, 14, 12);
    arm();
    @(negedge clock);
    check("t2_arm_mode1", 32'(armed), 0);
    cycles(1);
    mode = 1'b0;
    cycles(2);
    check("t2_no_vote", 32'(n_ok - ok0), 0);
    check("t2_counts", 32'(cand_count), 32'(model_counts()));

    // Second button qualifying while another is held is rejected.
    rej0 = n_rej;
    button_raw = 4'b0001;
    cycles(14);
    arm();
    cycles(2);
    e.is_vote = 1'b0;
    e.counts  = model_counts();
    exp_q.push_back(e);
    button_raw = 4'b0101;
    cycles(14);
    @(negedge clock);
    check("t3_reject", 32'(n_rej - rej0), 1);
    check("t3_still_armed", 32'(armed), 1);
    cycles(1);
    button_raw = '0;
    cycles(12);
    @(negedge clock);
    check("t3_rearmed", 32'(armed), 1);
    cycles(1);
    push_vote(2);
    press(4'b0100, 14, 12);
    check("t3_count3", 32'(cand_count[2*CW +: CW]), 1);

    // Tie between candidates 1 and 2, then broken.
    for (int k = 0; k < 3; k++) vote(0);
    for (int k = 0; k < 2; k++) vote(1);
    check("t4_tie_winner", 32'(winner_id), 1);
    check("t4_tie_votes", 32'(winner_votes), 3);
    check("t4_tie", 32'(tie), 1);
    check("t4_presat", 32'(saturated), 0);
    vote(1);
    check("t4_winner", 32'(winner_id), 2);
    check("t4_votes", 32'(winner_votes), 4);
    check("t4_no_tie", 32'(tie), 0);

    // Saturation of candidate 4.
    ok0 = n_ok;
    for (int k = 0; k < 16; k++) vote(3);
    check("t5_ok_pulses", 32'(n_ok - ok0), 16);
    check("t5_count4", 32'(cand_count[3*CW +: CW]), 15);
    check("t5_saturated", 32'(saturated), 1);
    check("t5_winner", 32'(winner_id), 4);

    // Result mode display, then reset during a press.
    mode = 1'b1;
    button_raw = 4'b0100;
    cycles(10);
    @(negedge clock);
    check("t6_led_held", 32'(led), 32'(mc[2]));
    cycles(1);
    button_raw = '0;
    cycles(10);
    @(negedge clock);
    check("t6_led_winner", 32'(led), 15);
    cycles(1);
    mode = 1'b0;
    ok0 = n_ok;
    arm();
    button_raw = 4'b0001;
    cycles(7);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    for (int i = 0; i < NC; i++) mc[i] = 0;
    cycles(10);
    button_raw = '0;
    cycles(12);
    @(negedge clock);
    check("t6_rst_counts", 32'(cand_count), 0);
    check("t6_rst_winner", {23'd0, winner_id, winner_votes, tie, saturated}, 0);
    check("t6_rst_armed_led", {27'd0, armed, led}, 0);
    check("t6_no_vote", 32'(n_ok - ok0), 0);
    check("sb_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/voting_machine_param.md
Name: voting_machine_param

Overview:
- Parametrised successor to the 4-candidate voting machine; supports NUM_CAND candidates with COUNT_W-bit tallies.
- Adds per-ballot arming by a presiding officer, rejection of multi-button presses, saturating counters and a registered winner/tie tracker.
- Sits between the raw board buttons/switches and the LED/7-seg display logic; one debounce/long-press channel per candidate.

Parameters:
- NUM_CAND, 4, number of candidates/buttons (2..15).
- COUNT_W, 8, width of each tally, winner_votes and led.
- DEBOUNCE_CYCLES, 500, cycles a synchronised input must be stable before the debounced level changes.
- LONG_PRESS_CYCLES, 11, cycles the debounced level must stay high for a press to count as a vote.
- BLINK_CYCLES, 16, cycles led is forced all-ones after an accepted vote.
- ID_W, $clog2(NUM_CAND+1), derived; width of winner_id. Not to be overridden.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high; clears all state
- mode  in  1  0 = voting, 1 = result
- ballot_arm  in  1  single-cycle pulse from officer; enables exactly one vote
- button_raw  in  NUM_CAND  asynchronous raw buttons; bit i = candidate i+1
- led  out  COUNT_W  blink / result display
- armed  out  1  high while a ballot is armed and unused
- vote_ok  out  1  1-cycle pulse when a vote is counted
- vote_reject  out  1  1-cycle pulse when a qualified press is rejected
- cand_count  out  NUM_CAND*COUNT_W  packed tallies; candidate i+1 in bits [i*COUNT_W +: COUNT_W]
- winner_id  out  ID_W  1-based leader; 0 when all tallies are 0
- winner_votes  out  COUNT_W  leader's tally
- tie  out  1  two or more candidates share a nonzero maximum
- saturated  out  1  sticky; set when any tally hits all-ones

Behaviour:
- Reset (synchronous, active-high): all outputs 0, all tallies 0, FSM in IDLE, sync/debounce/long-press counters 0. Reset asserted mid-press or mid-blink aborts it; no vote is counted.
- Per-channel input path:
  - 2-flop synchroniser.
  - Debounce counter: the debounced level takes the synchronised value after DEBOUNCE_CYCLES consecutive equal samples that differ from the current level.
  - Long-press counter: increments while the debounced level is high. When it reaches LONG_PRESS_CYCLES it emits a single-cycle qual_i and holds (one qual per press). It clears when the debounced level is low.
- FSM states:
  - IDLE: armed=0. ballot_arm with mode=0 -> ARMED. ballot_arm is ignored in every other state and when mode=1.
  - ARMED: armed=1.
    - Exactly one qual_i, with no other debounced button high -> tally i incremented next edge, vote_ok pulses, go to BLINK.
    - Any qual while another debounced button is high, or two quals in the same cycle -> vote_reject pulses, ballot stays armed, go to WAIT_REL.
    - mode rising to 1 -> disarm, go to IDLE.
  - BLINK: led = all-ones for BLINK_CYCLES cycles, then WAIT_REL.
  - WAIT_REL: wait until all debounced buttons are low. Then go to ARMED if the ballot is still held (reject path), else IDLE.
- Saturation: a tally at 2^COUNT_W-1 does not wrap. The vote is still consumed, vote_ok still pulses, and saturated is set and stays set until reset.
- Winner logic: registered, updates one cycle after any tally change.
  - winner_id is the lowest index among maximal tallies.
  - tie=1 iff at least two tallies equal the maximum and the maximum is >0.
  - All tallies 0 -> winner_id=0, winner_votes=0, tie=0.
- led:
  - mode=0: all-ones during BLINK, else 0.
  - mode=1: tally of the lowest-index debounced-high button. If no button is held, winner_votes. Registered, 1-cycle latency.
- Presses in IDLE or mode=1 never change tallies, vote_ok or vote_reject.

Test Plan (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=3, BLINK_CYCLES=4, NUM_CAND=4, COUNT_W=4):
- Reset then arm + long-press btn2 -> vote_ok 1 pulse, count2=1, led=F for 4 cycles, winner_id=2, winner_votes=1, tie=0, armed=0.
- Press btn1 with no arm, and press btn1 in mode=1 after arming -> all counts unchanged, no vote_ok. Arming in mode=1 leaves armed=0.
- Arm, hold btn1, then press btn3 until it qualifies -> vote_reject 1 pulse, counts unchanged. Release all, press btn3 -> count3=1.
- Arm/vote: c1=3, c2=3, c3=1 -> winner_id=1, winner_votes=3, tie=1. One more c2 vote -> winner_id=2, winner_votes=4, tie=0.
- 16 armed votes for btn4 -> count4 stays 15, saturated=1, 16th vote_ok still pulses.
- mode=1: hold btn3 -> led=count3. Release -> led=winner_votes. Assert reset mid-press -> all tallies and outputs 0, no vote counted.
